// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: load/store funct3 codes, FSM
// state encoding, the captured access context and type-legality helpers.
package mem_pkg;

  localparam int unsigned XLEN = 32;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Access context captured at accept; upstream may move on before the ack.
  typedef struct packed {
    logic       is_load;
    logic       reg_write;
    logic [4:0] rd;
    logic [2:0] load_type;
    logic [1:0] addr_lo;
  } acc_ctx_t;

  function automatic logic load_type_ok(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic store_type_ok(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-RAM request/response bus.
//   master: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be out; dmem_rdata, dmem_ack in
//   slave : the mirror image
interface mem_stage_if #(
  parameter int unsigned DMEM_AW = 30
) ();
  logic               dmem_req;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic [3:0]         dmem_be;
  logic [31:0]        dmem_rdata;
  logic               dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables and lane replication, load
// lane shift with sign/zero extension.
//   st_addr_lo_i/st_type_i/st_data_i -> st_be_c_o, st_wdata_c_o
//   ld_addr_lo_i/ld_type_i/ld_rdata_i -> ld_data_c_o
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]      st_addr_lo_i,
  input  logic [2:0]      st_type_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [1:0]      ld_addr_lo_i,
  input  logic [2:0]      ld_type_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [3:0]      st_be_c_o,
  output logic [XLEN-1:0] st_wdata_c_o,
  output logic [XLEN-1:0] ld_data_c_o
);

  logic [XLEN-1:0] ld_shift;

  // Store: byte/halfword replicated on every lane, enables select the lane
  always_comb begin
    st_be_c_o    = 4'b0000;
    st_wdata_c_o = st_data_i;
    case (st_type_i)
      F3_B: begin
        st_be_c_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_c_o = {4{st_data_i[7:0]}};
      end
      F3_H: begin
        st_be_c_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
        st_wdata_c_o = {2{st_data_i[15:0]}};
      end
      F3_W:    st_be_c_o = 4'b1111;
      default: st_be_c_o = 4'b0000;
    endcase
  end

  assign ld_shift = ld_rdata_i >> {ld_addr_lo_i, 3'b000};

  // Load: addressed byte lane moved to bit 0 then extended
  always_comb begin
    ld_data_c_o = '0;
    case (ld_type_i)
      F3_B:    ld_data_c_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data_c_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_W:    ld_data_c_o = ld_shift;
      F3_BU:   ld_data_c_o = {24'd0, ld_shift[7:0]};
      F3_HU:   ld_data_c_o = {16'd0, ld_shift[15:0]};
      default: ld_data_c_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through, issues one data-RAM
// access per load/store and waits for its ack, traps on misaligned or
// illegal accesses and on ack timeout.
//   clk, reset (sync, active low)
//   ex_* : EX/MEM payload and memory control, held by upstream while mem_stall
//   dmem : data-RAM master port
//   wb_* : registered MEM/WB outputs; mem_trap one-cycle trap pulse
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned DMEM_AW     = 30,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_ram_address,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_load_type,
  input  logic [2:0]  ex_store_type,
  input  logic        ex_misaligned,
  output logic        mem_stall,
  mem_stage_if.master dmem,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_result,
  output logic        wb_is_load,
  output logic        mem_trap
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  mem_state_e         state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [DMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  acc_ctx_t           ctx_q, ctx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stall_q, stall_d;
  logic               wb_valid_q, wb_valid_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic               wb_reg_write_q, wb_reg_write_d;
  logic [31:0]        wb_result_q, wb_result_d;
  logic               wb_is_load_q, wb_is_load_d;
  logic               trap_q, trap_d;

  logic [3:0]         st_be;
  logic [31:0]        st_wdata;
  logic [31:0]        ld_data;
  logic               mem_op;
  logic               type_ok;
  logic               timeout_hit;

  lsu_align u_align (
    .st_addr_lo_i (ex_ram_address[1:0]),
    .st_type_i    (ex_store_type),
    .st_data_i    (ex_store_data),
    .ld_addr_lo_i (ctx_q.addr_lo),
    .ld_type_i    (ctx_q.load_type),
    .ld_rdata_i   (dmem.dmem_rdata),
    .st_be_c_o    (st_be),
    .st_wdata_c_o (st_wdata),
    .ld_data_c_o  (ld_data)
  );

  assign mem_op  = ex_is_load | ex_is_store;
  // An op flagged as both load and store is treated as an illegal type
  assign type_ok = ex_is_load ? (!ex_is_store && load_type_ok(ex_load_type))
                              : store_type_ok(ex_store_type);
  // Last permitted WAIT cycle reached without ack; zero timeout never fires
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    ctx_d          = ctx_q;
    cnt_d          = cnt_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = 5'd0;
    wb_reg_write_d = 1'b0;
    wb_result_d    = 32'd0;
    wb_is_load_d   = 1'b0;
    trap_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (!mem_op) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = ex_reg_write;
            wb_rd_d        = ex_reg_write ? ex_rd : 5'd0;
            wb_result_d    = ex_result;
          end else if (ex_misaligned || !type_ok) begin
            wb_valid_d = 1'b1;
            trap_d     = 1'b1;
          end else begin
            req_d   = 1'b1;
            we_d    = ex_is_store;
            addr_d  = ex_ram_address[DMEM_AW+1:2];
            be_d    = ex_is_store ? st_be : 4'b1111;
            wdata_d = ex_is_store ? st_wdata : 32'd0;
            ctx_d   = '{is_load:   ex_is_load,
                        reg_write: ex_reg_write,
                        rd:        ex_rd,
                        load_type: ex_load_type,
                        addr_lo:   ex_ram_address[1:0]};
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem.dmem_ack) begin
          req_d      = 1'b0;
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          if (ctx_q.is_load) begin
            wb_reg_write_d = ctx_q.reg_write;
            wb_rd_d        = ctx_q.reg_write ? ctx_q.rd : 5'd0;
            wb_result_d    = ld_data;
            wb_is_load_d   = 1'b1;
          end
        end else if (timeout_hit) begin
          req_d      = 1'b0;
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          trap_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    stall_d = (state_d == ST_WAIT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= 32'd0;
      be_q           <= 4'd0;
      ctx_q          <= '0;
      cnt_q          <= '0;
      stall_q        <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      wb_result_q    <= 32'd0;
      wb_is_load_q   <= 1'b0;
      trap_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      ctx_q          <= ctx_d;
      cnt_q          <= cnt_d;
      stall_q        <= stall_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_result_q    <= wb_result_d;
      wb_is_load_q   <= wb_is_load_d;
      trap_q         <= trap_d;
    end
  end

  assign mem_stall       = stall_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;
  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;
  assign wb_reg_write    = wb_reg_write_q;
  assign wb_result       = wb_result_q;
  assign wb_is_load      = wb_is_load_q;
  assign mem_trap        = trap_q;

endmodule
